// File: rtl/vga_text_console_writer.sv
// Terminal-style writer for the character RAM cpu port. It tracks a cursor,
// interprets CR/LF/BS/TAB/FF, clears the screen and scrolls by RAM read-back.
module vga_text_console_writer #(
  parameter int         N_COL      = 80,
  parameter int         N_ROW      = 30,
  parameter int         ADDR_W     = 12,
  parameter logic [7:0] BLANK_CHAR = 8'h20
) (
  input  logic              cpu_clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  input  logic [7:0]        attr,
  output logic              busy,
  output logic [6:0]        cursor_col,
  output logic [4:0]        cursor_row,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic              ram_oe,
  output logic [15:0]       ram_wdata,
  input  logic [15:0]       ram_rdata
);

  // Byte handshake: a byte transfers on a rising edge where in_valid and
  // in_ready are both 1; in_ready is only ever 1 in IDLE.

  localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(N_COL);
  localparam logic [ADDR_W-1:0] LAST_A    = ADDR_W'(N_COL * N_ROW - 1);
  localparam logic [ADDR_W-1:0] ROWBASE_A = ADDR_W'((N_ROW - 1) * N_COL);
  localparam logic [ADDR_W-1:0] ONE_A     = ADDR_W'(1);
  localparam logic [7:0]        N_COL_8   = 8'(N_COL);
  localparam logic [4:0]        ROW_LAST  = 5'(N_ROW - 1);

  localparam logic [7:0] CH_BS  = 8'h08;
  localparam logic [7:0] CH_TAB = 8'h09;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_FF  = 8'h0C;
  localparam logic [7:0] CH_CR  = 8'h0D;

  typedef enum logic [2:0] {
    S_CLR_ALL,
    S_IDLE,
    S_EXEC,
    S_SCR_RD,
    S_SCR_WR,
    S_CLR_LINE
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] idx, idx_n;
  logic [6:0]        col, col_n;
  logic [4:0]        row, row_n;
  logic [7:0]        byte_q, byte_n;
  logic [7:0]        attr_q, attr_n;
  logic              we_n, oe_n, ready_n, busy_n;
  logic [ADDR_W-1:0] addr_n;
  logic [15:0]       wdata_q, wdata_n;

  logic [ADDR_W-1:0] cell_addr;
  logic [7:0]        col_inc;
  logic [7:0]        tab_col;
  logic              adv;
  logic              ff;

  function automatic logic is_print(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    col_n     = col;
    row_n     = row;
    byte_n    = byte_q;
    attr_n    = attr_q;
    we_n      = 1'b0;
    oe_n      = 1'b0;
    addr_n    = ram_addr;
    wdata_n   = wdata_q;
    ready_n   = 1'b0;
    busy_n    = 1'b1;
    adv       = 1'b0;
    ff        = 1'b0;
    cell_addr = ADDR_W'(row) * COLS_A + ADDR_W'(col);
    col_inc   = {1'b0, col} + 8'd1;
    tab_col   = {1'b0, col | 7'd7} + 8'd1;

    case (state)
      // The first cycle of a clear never writes (ram_we is 0 there), so
      // ram_we doubles as "address 0 already issued".
      S_CLR_ALL: begin
        if (ram_we && (ram_addr == LAST_A)) begin
          state_n = S_IDLE;
          ready_n = 1'b1;
          busy_n  = 1'b0;
        end else begin
          we_n    = 1'b1;
          addr_n  = ram_we ? ram_addr + ONE_A : '0;
          wdata_n = {attr_q, BLANK_CHAR};
        end
      end

      S_IDLE: begin
        ready_n = 1'b1;
        busy_n  = 1'b0;
        if (in_valid && in_ready) begin
          state_n = S_EXEC;
          byte_n  = in_data;
          attr_n  = attr;
          ready_n = 1'b0;
          busy_n  = 1'b1;
          // The EXEC write strobe is registered here so it lands in EXEC itself.
          if (is_print(in_data)) begin
            we_n    = 1'b1;
            addr_n  = cell_addr;
            wdata_n = {attr, in_data};
          end
        end
      end

      S_EXEC: begin
        state_n = S_IDLE;
        ready_n = 1'b1;
        busy_n  = 1'b0;
        if (is_print(byte_q)) begin
          if (col_inc == N_COL_8) begin
            col_n = '0;
            adv   = 1'b1;
          end else begin
            col_n = col_inc[6:0];
          end
        end else begin
          case (byte_q)
            CH_CR: col_n = '0;
            CH_LF: begin
              col_n = '0;
              adv   = 1'b1;
            end
            CH_BS: if (col != '0) col_n = col - 7'd1;
            CH_TAB: begin
              if (tab_col >= N_COL_8) begin
                col_n = '0;
                adv   = 1'b1;
              end else begin
                col_n = tab_col[6:0];
              end
            end
            CH_FF: begin
              col_n = '0;
              row_n = '0;
              ff    = 1'b1;
            end
            default: ;
          endcase
        end

        if (ff) begin
          state_n = S_CLR_ALL;
          ready_n = 1'b0;
          busy_n  = 1'b1;
        end else if (adv) begin
          if (row == ROW_LAST) begin
            state_n = S_SCR_RD;
            ready_n = 1'b0;
            busy_n  = 1'b1;
            oe_n    = 1'b1;
            addr_n  = COLS_A;
            idx_n   = COLS_A;
          end else begin
            row_n = row + 5'd1;
          end
        end
      end

      S_SCR_RD: begin
        state_n = S_SCR_WR;
        we_n    = 1'b1;
        addr_n  = idx - COLS_A;
      end

      S_SCR_WR: begin
        if (idx == LAST_A) begin
          state_n = S_CLR_LINE;
          we_n    = 1'b1;
          addr_n  = ROWBASE_A;
          wdata_n = {attr_q, BLANK_CHAR};
        end else begin
          state_n = S_SCR_RD;
          idx_n   = idx + ONE_A;
          oe_n    = 1'b1;
          addr_n  = idx + ONE_A;
        end
      end

      S_CLR_LINE: begin
        if (ram_addr == LAST_A) begin
          state_n = S_IDLE;
          ready_n = 1'b1;
          busy_n  = 1'b0;
        end else begin
          we_n    = 1'b1;
          addr_n  = ram_addr + ONE_A;
          wdata_n = {attr_q, BLANK_CHAR};
        end
      end

      default: begin
        state_n = S_CLR_ALL;
      end
    endcase
  end

  always_ff @(posedge cpu_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_CLR_ALL;
      idx      <= '0;
      col      <= '0;
      row      <= '0;
      byte_q   <= '0;
      attr_q   <= '0;
      ram_we   <= 1'b0;
      ram_oe   <= 1'b0;
      ram_addr <= '0;
      wdata_q  <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b1;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      col      <= col_n;
      row      <= row_n;
      byte_q   <= byte_n;
      attr_q   <= attr_n;
      ram_we   <= we_n;
      ram_oe   <= oe_n;
      ram_addr <= addr_n;
      wdata_q  <= wdata_n;
      in_ready <= ready_n;
      busy     <= busy_n;
    end
  end

  // Read data only arrives in the SCR_WR cycle itself, so the copy path
  // forwards it straight to the write port instead of through wdata_q.
  assign ram_wdata  = (state == S_SCR_WR) ? ram_rdata : wdata_q;
  assign cursor_col = col;
  assign cursor_row = row;

endmodule

// File: tb/tb_vga_text_console_writer.sv
// Bench for vga_text_console_writer: a character-RAM model, a screen/cursor
// reference model and a write scoreboard fed by the stimulus.
module tb_vga_text_console_writer;

  localparam int N_COL  = 80;
  localparam int N_ROW  = 30;
  localparam int ADDR_W = 12;
  localparam int CELLS  = N_COL * N_ROW;
  localparam int SCROLL_CYCLES = 2 * N_COL * (N_ROW - 1) + N_COL;

  logic              cpu_clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_data;
  logic [7:0]        attr;
  logic              busy;
  logic [6:0]        cursor_col;
  logic [4:0]        cursor_row;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic              ram_oe;
  logic [15:0]       ram_wdata;
  logic [15:0]       ram_rdata;

  int checks = 0;
  int errors = 0;

  logic [27:0] exp_q[$];
  logic [15:0] mem [0:4095];
  logic [15:0] scr [0:CELLS-1];
  int          m_col;
  int          m_row;
  logic [7:0]  m_attr;
  bit          ram_seeded = 1'b0;

  vga_text_console_writer dut (
    .cpu_clk    (cpu_clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .attr       (attr),
    .busy       (busy),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_oe     (ram_oe),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  // ---------------- clock ----------------
  always #5 cpu_clk = ~cpu_clk;

  // Character RAM cpu port: synchronous write, registered read. Contents start
  // as garbage so that clears are really observed.
  always @(posedge cpu_clk) begin
    if (!ram_seeded) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 16'($urandom);
      ram_seeded <= 1'b1;
    end else begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      if (ram_oe) ram_rdata <= mem[ram_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic push_write(input int a, input logic [15:0] d);
    exp_q.push_back({12'(a), d});
    scr[a] = d;
  endtask

  task automatic model_clear_all();
    for (int i = 0; i < CELLS; i++) push_write(i, {m_attr, 8'h20});
  endtask

  task automatic model_newline(output bit scrolled);
    scrolled = 1'b0;
    m_col = 0;
    if (m_row == N_ROW - 1) begin
      scrolled = 1'b1;
      for (int i = 0; i < CELLS - N_COL; i++) push_write(i, scr[i + N_COL]);
      for (int i = CELLS - N_COL; i < CELLS; i++) push_write(i, {m_attr, 8'h20});
    end else begin
      m_row++;
    end
  endtask

  task automatic model_byte(input logic [7:0] b, input logic [7:0] a,
                            output bit we_now, output bit long_op);
    m_attr  = a;
    we_now  = 1'b0;
    long_op = 1'b0;
    if (b >= 8'h20 && b <= 8'h7E) begin
      push_write(m_row * N_COL + m_col, {a, b});
      we_now = 1'b1;
      m_col++;
      if (m_col == N_COL) model_newline(long_op);
    end else begin
      case (b)
        8'h0D: m_col = 0;
        8'h0A: model_newline(long_op);
        8'h08: if (m_col > 0) m_col--;
        8'h09: begin
          m_col = (m_col | 7) + 1;
          if (m_col >= N_COL) model_newline(long_op);
        end
        8'h0C: begin
          m_col = 0;
          m_row = 0;
          model_clear_all();
          long_op = 1'b1;
        end
        default: ;
      endcase
    end
  endtask

  function automatic int screen_diff();
    int n = 0;
    for (int i = 0; i < CELLS; i++) if (mem[i] !== scr[i]) n++;
    return n;
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge cpu_clk) begin
    if (rst_n === 1'b1) begin
      if (ram_we || ram_oe) check("we_oe_exclusive", 32'(ram_we & ram_oe), 32'd0);
      if (ram_we) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write at %0t",
                   ram_addr, ram_wdata, $time);
        end else begin
          check("ram_write", 32'({ram_addr, ram_wdata}), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_cursor(input string name);
    check(name, 32'({cursor_row, cursor_col}), 32'({5'(m_row), 7'(m_col)}));
  endtask

  task automatic wait_ready(input string name, input int budget, output int lowc);
    lowc = 0;
    while (!in_ready && lowc < budget) begin
      lowc++;
      @(negedge cpu_clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got in_ready 0 after %0d cycles expected 1", name, budget);
    end
  endtask

  // Called at a negedge with in_ready=1; returns just after the accepting edge.
  task automatic issue_byte(input logic [7:0] b, input logic [7:0] a,
                            output bit we_now, output bit long_op);
    in_valid = 1'b1;
    in_data  = b;
    attr     = a;
    model_byte(b, a, we_now, long_op);
    @(posedge cpu_clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic [7:0] a,
                           input int budget, output int lowc);
    bit we_now, long_op;
    issue_byte(b, a, we_now, long_op);
    @(negedge cpu_clk);
    check("strobe_we", 32'(ram_we), 32'(we_now));
    check("ready_drop", 32'(in_ready), 32'd0);
    wait_ready("byte", budget, lowc);
    check_cursor("cursor");
  endtask

  function automatic logic [7:0] rand_print();
    return 8'($urandom_range(32, 126));
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected finish before 900000 ns");
    $fatal(1, "watchdog");
  end

  // ---------------- main stimulus ----------------
  initial begin
    int          lowc;
    int          wait_n;
    int          ready_cnt;
    int          r;
    bit          we_now, long_op;
    logic [7:0]  b;
    logic [15:0] saved;

    in_valid = 1'b0;
    in_data  = 8'h00;
    attr     = 8'h00;
    rst_n    = 1'b0;
    m_col    = 0;
    m_row    = 0;
    m_attr   = 8'h00;

    repeat (3) @(negedge cpu_clk);
    check("rst_we", 32'(ram_we), 32'd0);
    check("rst_oe", 32'(ram_oe), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_cursor", 32'({cursor_row, cursor_col}), 32'd0);
    check("rst_addr", 32'(ram_addr), 32'd0);
    check("rst_wdata", 32'(ram_wdata), 32'd0);

    model_clear_all();
    rst_n = 1'b1;
    wait_ready("clear_all", 3000, lowc);
    check("clear_all_writes_left", exp_q.size(), 0);
    check_cursor("cursor_after_clear");
    check("screen_after_reset", screen_diff(), 0);

    send_byte(8'h41, 8'h1F, 10, lowc);
    check("A_ready_low_cycles", lowc, 1);
    check("A_cell", 32'(mem[0]), 32'h1F41);

    // Move to (79,5).
    send_byte(8'h0D, 8'($urandom), 10, lowc);
    repeat (5) send_byte(8'h0A, 8'($urandom), 10, lowc);
    repeat (79) send_byte(rand_print(), 8'($urandom), 10, lowc);
    check("cursor_79_5", 32'({cursor_row, cursor_col}), 32'({5'd5, 7'd79}));
    send_byte(8'h5A, 8'h2E, 10, lowc);
    check("Z_cell", 32'(mem[479]), 32'h2E5A);
    check("Z_cursor", 32'({cursor_row, cursor_col}), 32'({5'd6, 7'd0}));
    send_byte(8'h08, 8'h2E, 10, lowc);
    check("BS_cursor", 32'({cursor_row, cursor_col}), 32'({5'd6, 7'd0}));

    // Move to (3,29), then LF forces a scroll.
    repeat (23) send_byte(8'h0A, 8'($urandom), 10, lowc);
    repeat (3) send_byte(rand_print(), 8'($urandom), 10, lowc);
    saved = scr[N_COL];
    send_byte(8'h0A, 8'h4C, 6000, lowc);
    // One EXEC cycle precedes the scroll itself.
    check("scroll_cycles", lowc - 1, SCROLL_CYCLES);
    check("scroll_cursor", 32'({cursor_row, cursor_col}), 32'({5'd29, 7'd0}));
    check("scroll_row0_cell0", 32'(mem[0]), 32'(saved));
    check("scroll_last_row_blank", 32'(mem[CELLS - 1]), 32'h4C20);
    check("screen_after_scroll", screen_diff(), 0);

    // FF, then to (5,2) for TAB/CR, then FF again.
    send_byte(8'h0C, 8'($urandom), 3000, lowc);
    repeat (2) send_byte(8'h0A, 8'($urandom), 10, lowc);
    repeat (5) send_byte(rand_print(), 8'($urandom), 10, lowc);
    send_byte(8'h09, 8'($urandom), 10, lowc);
    check("TAB_cursor", 32'({cursor_row, cursor_col}), 32'({5'd2, 7'd8}));
    send_byte(8'h0D, 8'($urandom), 10, lowc);
    check("CR_cursor", 32'({cursor_row, cursor_col}), 32'({5'd2, 7'd0}));
    send_byte(8'h0C, 8'h71, 3000, lowc);
    check("FF_cursor", 32'({cursor_row, cursor_col}), 32'd0);
    check("FF_writes_left", exp_q.size(), 0);
    check("screen_after_FF", screen_diff(), 0);

    // Held BEL: one accept every second cycle, nothing written.
    in_valid  = 1'b1;
    in_data   = 8'h07;
    attr      = 8'h5A;
    ready_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) ready_cnt++;
      @(negedge cpu_clk);
    end
    in_valid = 1'b0;
    m_attr   = 8'h5A;
    check("BEL_accepts_in_20", ready_cnt, 10);
    check_cursor("BEL_cursor");

    // Randomised byte stream.
    for (int n = 0; n < 120; n++) begin
      r = $urandom_range(0, 99);
      if (r < 70) begin
        b = rand_print();
      end else begin
        case ($urandom_range(0, 6))
          0: b = 8'h0D;
          1: b = 8'h0A;
          2: b = 8'h08;
          3: b = 8'h09;
          4: b = 8'h07;
          5: b = 8'($urandom_range(128, 255));
          default: b = 8'h7F;
        endcase
      end
      send_byte(b, 8'($urandom), 6000, lowc);
    end
    check("screen_after_random", screen_diff(), 0);

    // Reset in the middle of a scroll.
    while (m_row != N_ROW - 1) send_byte(8'h0A, 8'($urandom), 10, lowc);
    issue_byte(8'h0A, 8'($urandom), we_now, long_op);
    wait_n = $urandom_range(50, 4000);
    repeat (wait_n) @(negedge cpu_clk);
    #2;
    check("mid_scroll_active", 32'(ram_we | ram_oe), 32'd1);
    rst_n = 1'b0;
    #1;
    check("reset_kills_we_oe", 32'({ram_we, ram_oe}), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge cpu_clk);
    check("reset_ready", 32'(in_ready), 32'd0);
    check("reset_cursor", 32'({cursor_row, cursor_col}), 32'd0);
    m_col  = 0;
    m_row  = 0;
    m_attr = 8'h00;
    model_clear_all();
    rst_n = 1'b1;
    wait_ready("clear_after_reset", 3000, lowc);
    check("clear_after_reset_writes_left", exp_q.size(), 0);
    check("screen_after_reset2", screen_diff(), 0);
    send_byte(rand_print(), 8'($urandom), 10, lowc);
    check("final_writes_left", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
